seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Receive-side counterpart of the multiplexed seven-segment driver: samples a time-multiplexed anode/segment bus (active-low, 8 anodes), waits for each scan slot to settle, decodes the segment pattern back to a hex nibble and stores it per digit. Used as a loopback and self-check monitor beside the display path, and as the front end for boards that receive another unit's display bus. All outputs are registered in the `clk_in` domain.

## Interface
- `STABLE_CNT`, default 4: consecutive identical `sample_en` samples required before a pattern is accepted. Legal range is 1..15; the counter is 4 bits.
- `clk_in`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `sample_en`  in  1  one-cycle sample strobe, e.g. 500 Hz × 8, from the clock divider.
- `AN_in`  in  8  anode bus, active-low, asynchronous to `clk_in`.
- `seg_in`  in  7  segment bus `{g,f,e,d,c,b,a}`, active-low, asynchronous.
- `digit_out`  out  32  eight nibbles; digit i is `[4i+3:4i]`.
- `digit_valid`  out  8  bit i = digit i holds a legally decoded value.
- `seg_err`  out  8  bit i = the last accepted pattern for digit i was illegal.
- `an_err`  out  1  one-cycle pulse: an accepted pattern drove more than one anode low.
- `update`  out  1  one-cycle pulse on every accept with a single active anode.
- `frame_done`  out  1  one-cycle pulse when a scan wraps.

## Operation
- **Synchronizer.** A 2-FF synchronizer samples the 15 bits `{AN_in, seg_in}`. It resets to all ones. `S` is the synchronizer output.
- **Stability counter.** Registers `prev` (15 bits, reset all ones) and `cnt` (4 bits, reset 0). They update only on `sample_en`:
  - If `S != prev`: `prev <= S`, `cnt <= 1`.
  - Otherwise, if `cnt < STABLE_CNT`: `cnt <= cnt + 1`.
  - Saturated: `cnt` holds at `STABLE_CNT`.
- **Accept.** An accept occurs on the `sample_en` cycle where the next value of `cnt` equals `STABLE_CNT` and the current `cnt != STABLE_CNT`. A stable pattern is accepted exactly once; it can be accepted again only after a change.
- **Anode check at accept.**
  - `AN` all ones: blanking slot, ignored, no outputs change.
  - More than one zero: `an_err` pulses, no other change.
  - Exactly one zero at bit i: digit i is processed and `update` pulses.
- **Segment decode (hex, `{g..a}`, active-low).**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Legal pattern: nibble i <= value, `digit_valid[i]` <= 1, `seg_err[i]` <= 0.
  - 7F (blank): `digit_valid[i]` <= 0, `seg_err[i]` <= 0, nibble unchanged.
  - Any other pattern: `digit_valid[i]` <= 0, `seg_err[i]` <= 1, nibble unchanged.
- **Frame detect.** `last_idx` (3 bits) and `last_v` (1 bit) reset to 0.
  - On an accepted single-anode digit i: if `last_v` and i <= `last_idx`, `frame_done` pulses. Then `last_idx` <= i and `last_v` <= 1.
  - Consequence: a single-digit display pulses on every re-accept of the same digit after a change.
- **Reset.** Reset at any time, including mid-count, returns all state to reset values immediately (asynchronous). Reset values:
  - `digit_out` = 0, `digit_valid` = 0, `seg_err` = 0.
  - `an_err` = 0, `update` = 0, `frame_done` = 0.
  - `prev` = 7FFF, `cnt` = 0.

## Timing
- Pin to `S`: 2 `clk_in` edges.
- An accept happens on the STABLE_CNT-th `sample_en` that sees the new `S`, counting the one that detected the change.
- Outputs update on the clock edge of that accepting `sample_en` cycle. Pulses are high for exactly that one following cycle.
- `update`, `frame_done` and digit register writes are coincident; `an_err` is exclusive with all three.
- `sample_en` low: no state changes except the synchronizer.
- `sample_en` held high continuously is legal and means every cycle is a sample.
- A pattern that changes before `STABLE_CNT` samples is never accepted; glitches of fewer samples are filtered.

## Test plan
1. **Basic accept.** Reset, `STABLE_CNT`=4, strobe every cycle. Drive AN=FE, seg=30 for 10 cycles.
   - Expect exactly one `update` pulse 6 cycles after the change (2 sync + 4 samples).
   - Expect `digit_out[3:0]`=3 and `digit_valid`=01.
2. **Two-digit scan.** Alternate AN=FE/seg=12 and AN=FD/seg=0E, 8 strobes each, 3 rounds.
   - Expect `digit_out[7:0]`=F5 and `digit_valid`=03.
   - Expect `frame_done` on each return to digit 0 (2 pulses), and 6 `update` pulses.
3. **Glitch filter.** Hold FE/40, insert FE/79 for 3 strobes, then return to 40.
   - Expect no accept of 1, and nibble 0 stays 0.
   - Expect one `update` when 40 re-stabilises.
4. **Illegal and blank patterns.**
   - Digit 2 with seg=7E: `seg_err`=04, `digit_valid[2]`=0, nibble 2 unchanged.
   - Then seg=7F: `seg_err[2]`=0.
   - AN=FF: no pulses at all.
5. **Multi-anode.** AN=FC, seg=00 stable.
   - Expect exactly one `an_err` pulse, no `update`, and registers unchanged.
6. **Reset mid-operation.** Assert `rst` low with `cnt`=2 and `digit_valid`=FF.
   - Expect all outputs 0 asynchronously.
   - After release with the same stable input, expect the accept to need 2 + `STABLE_CNT` cycles again.

Source files
------------

// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - display-bus capture signals: strobe, sampled bus, decoded digits and event pulses
interface seven_seg_capture_if;
    logic        sample_en;
    logic [7:0]  AN_in;
    logic [6:0]  seg_in;
    logic [31:0] digit_out;
    logic [7:0]  digit_valid;
    logic [7:0]  seg_err;
    logic        an_err;
    logic        update;
    logic        frame_done;

    modport master (
        output sample_en, AN_in, seg_in,
        input  digit_out, digit_valid, seg_err, an_err, update, frame_done
    );

    modport slave (
        input  sample_en, AN_in, seg_in,
        output digit_out, digit_valid, seg_err, an_err, update, frame_done
    );
endinterface

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - samples a multiplexed active-low 7-seg bus and rebuilds the per-digit hex values
module seven_seg_capture #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    seven_seg_capture_if.slave bus
);
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [14:0] sync1, sync2, prev;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic [7:0]  an_act;
    logic [6:0]  seg;
    logic        single;
    logic [2:0]  idx;
    logic        legal, blank;
    logic [3:0]  nib;
    logic [2:0]  last_idx;
    logic        last_v;
    logic [31:0] digit_q;
    logic [7:0]  valid_q, err_q;
    logic        an_err_q, update_q, frame_q;

    assign an_act = ~sync2[14:7];
    assign seg    = sync2[6:0];
    assign single = (an_act != 8'd0) && ((an_act & (an_act - 8'd1)) == 8'd0);
    assign blank  = (seg == 7'h7F);

    always_comb begin
        cnt_nxt = cnt;
        if (sync2 != prev)
            cnt_nxt = 4'd1;
        else if (cnt < STABLE)
            cnt_nxt = cnt + 4'd1;
    end

    // The change term keeps STABLE_CNT=1 accepting every new pattern while cnt sits at 1.
    assign accept = bus.sample_en && (cnt_nxt == STABLE) && ((cnt != STABLE) || (sync2 != prev));

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (an_act[i]) idx = 3'(i);
    end

    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (seg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1    <= '1;
            sync2    <= '1;
            prev     <= '1;
            cnt      <= 4'd0;
            digit_q  <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            an_err_q <= 1'b0;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
            last_idx <= 3'd0;
            last_v   <= 1'b0;
        end else begin
            sync1    <= {bus.AN_in, bus.seg_in};
            sync2    <= sync1;
            an_err_q <= 1'b0;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
            if (bus.sample_en) begin
                prev <= sync2;
                cnt  <= cnt_nxt;
            end
            if (accept) begin
                if (an_act != 8'd0 && !single) begin
                    an_err_q <= 1'b1;
                end else if (single) begin
                    update_q <= 1'b1;
                    if (legal) begin
                        digit_q[{idx, 2'b00} +: 4] <= nib;
                        valid_q[idx] <= 1'b1;
                        err_q[idx]   <= 1'b0;
                    end else begin
                        valid_q[idx] <= 1'b0;
                        err_q[idx]   <= !blank;
                    end
                    // Non-increasing digit index means the scan wrapped.
                    if (last_v && idx <= last_idx)
                        frame_q <= 1'b1;
                    last_idx <= idx;
                    last_v   <= 1'b1;
                end
            end
        end
    end

    assign bus.digit_out   = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.seg_err     = err_q;
    assign bus.an_err      = an_err_q;
    assign bus.update      = update_q;
    assign bus.frame_done  = frame_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed vector bench for seven_seg_capture
module tb_seven_seg_capture;
    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    seven_seg_capture_if bus ();

    seven_seg_capture #(.STABLE_CNT(4)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic [3:0] nib;
        logic       valid;
        logic       err;
        logic       frame;
    } vec_t;

    vec_t tbl [19];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cnt_upd, cnt_frm, cnt_anerr, lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [6:0] seg);
        bus.AN_in  = an;
        bus.seg_in = seg;
    endtask

    // Runs n cycles, sampling on falling edges; records pulse counts and first update latency.
    task automatic run(input int n);
        cnt_upd = 0; cnt_frm = 0; cnt_anerr = 0; lat = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk_in);
            if (bus.update) begin
                cnt_upd++;
                if (lat == 0) lat = c;
            end
            if (bus.frame_done) cnt_frm++;
            if (bus.an_err) cnt_anerr++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b0;
        drive(8'hFF, 7'h7F);
        run(2);
        rst = 1'b1;
        run(6);
    endtask

    function automatic vec_t mk(input logic [7:0] an, input logic [6:0] seg, input logic [3:0] nib,
                                input logic valid, input logic err, input logic frame);
        vec_t v;
        v.an = an; v.seg = seg; v.nib = nib; v.valid = valid; v.err = err; v.frame = frame;
        return v;
    endfunction

    function automatic int digit_of(input logic [7:0] an);
        int d = 0;
        for (int i = 0; i < 8; i++)
            if (!an[i]) d = i;
        return d;
    endfunction

    initial begin
        logic [6:0] hex_seg [16];
        logic [31:0] dv;
        int d;
        hex_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int k = 0; k < 16; k++)
            tbl[k] = mk(~(8'd1 << (k % 8)), hex_seg[k], 4'(k), 1'b1, 1'b0, k == 8);
        tbl[16] = mk(8'hFE, 7'h7E, 4'h8, 1'b0, 1'b1, 1'b1);
        tbl[17] = mk(8'hFE, 7'h7F, 4'h8, 1'b0, 1'b0, 1'b1);
        tbl[18] = mk(8'hFD, 7'h7F, 4'h9, 1'b0, 1'b0, 1'b0);

        bus.sample_en = 1'b1;
        drive(8'hFF, 7'h7F);
        run(3);
        check("reset digit_out", bus.digit_out, 32'h0);
        check("reset digit_valid", {24'h0, bus.digit_valid}, 32'h0);
        check("reset seg_err", {24'h0, bus.seg_err}, 32'h0);
        check("reset pulses", {29'h0, bus.an_err, bus.update, bus.frame_done}, 32'h0);
        rst = 1'b1;
        run(6);

        // Basic accept and latency
        drive(8'hFE, 7'h30);
        run(10);
        check("basic latency", lat, 6);
        check("basic updates", cnt_upd, 1);
        check("basic nibble", {28'h0, bus.digit_out[3:0]}, 32'h3);
        check("basic valid", {24'h0, bus.digit_valid}, 32'h01);

        // Two-digit scan
        do_reset();
        cnt_upd = 0;
        begin
            int upd = 0, frm = 0;
            for (int r = 0; r < 6; r++) begin
                if (r % 2 == 0) drive(8'hFE, 7'h12); else drive(8'hFD, 7'h0E);
                run(8);
                upd += cnt_upd; frm += cnt_frm;
            end
            check("scan updates", upd, 6);
            check("scan frames", frm, 2);
        end
        check("scan digits", {24'h0, bus.digit_out[7:0]}, 32'hF5);
        check("scan valid", {24'h0, bus.digit_valid}, 32'h03);

        // Glitch filter
        drive(8'hFE, 7'h40);
        run(8);
        drive(8'hFE, 7'h79);
        run(3);
        check("glitch no accept", cnt_upd, 0);
        drive(8'hFE, 7'h40);
        run(8);
        check("glitch restabilise", cnt_upd, 1);
        check("glitch nibble", bus.digit_out, 32'h0000_00F0);

        // Illegal and blank on digit 2
        drive(8'hFB, 7'h24);
        run(8);
        check("digit2 legal", bus.digit_out, 32'h0000_02F0);
        drive(8'hFB, 7'h7E);
        run(8);
        check("illegal seg_err", {24'h0, bus.seg_err}, 32'h04);
        check("illegal valid", {24'h0, bus.digit_valid}, 32'h03);
        check("illegal nibble kept", bus.digit_out, 32'h0000_02F0);
        drive(8'hFB, 7'h7F);
        run(8);
        check("blank seg_err", {24'h0, bus.seg_err}, 32'h00);
        drive(8'hFF, 7'h00);
        run(10);
        check("blanking slot pulses", cnt_upd + cnt_frm + cnt_anerr, 0);

        // Multi-anode
        drive(8'hFC, 7'h00);
        run(10);
        check("multi an_err", cnt_anerr, 1);
        check("multi update", cnt_upd, 0);
        check("multi digits", bus.digit_out, 32'h0000_02F0);
        check("multi valid", {24'h0, bus.digit_valid}, 32'h03);

        // Sample strobe held low freezes the counter
        bus.sample_en = 1'b0;
        drive(8'hFE, 7'h79);
        run(12);
        check("no strobe no update", cnt_upd, 0);
        bus.sample_en = 1'b1;
        run(8);
        check("strobe resumes", cnt_upd, 1);
        check("strobe nibble", bus.digit_out, 32'h0000_02F1);

        // Decode table across all digits
        do_reset();
        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].an, tbl[k].seg);
            run(8);
            d = digit_of(tbl[k].an);
            dv = bus.digit_out;
            check($sformatf("vec%0d nibble", k), {28'h0, dv[4*d +: 4]}, {28'h0, tbl[k].nib});
            check($sformatf("vec%0d valid", k), {31'h0, bus.digit_valid[d]}, {31'h0, tbl[k].valid});
            check($sformatf("vec%0d err", k), {31'h0, bus.seg_err[d]}, {31'h0, tbl[k].err});
            check($sformatf("vec%0d update", k), cnt_upd, 1);
            check($sformatf("vec%0d frame", k), cnt_frm, {31'h0, tbl[k].frame});
            if (k == 15) check("table full word", bus.digit_out, 32'hFEDC_BA98);
        end

        // Asynchronous reset mid-count
        for (int i = 0; i < 8; i++) begin
            drive(~(8'd1 << i), 7'h00);
            run(8);
        end
        check("all valid", {24'h0, bus.digit_valid}, 32'hFF);
        drive(8'hFE, 7'h40);
        run(4);
        #2 rst = 1'b0;
        #1;
        check("async digit_out", bus.digit_out, 32'h0);
        check("async valid", {24'h0, bus.digit_valid}, 32'h0);
        check("async pulses", {24'h0, bus.seg_err} | {29'h0, bus.an_err, bus.update, bus.frame_done}, 32'h0);
        @(negedge clk_in);
        rst = 1'b1;
        run(10);
        check("post-reset latency", lat, 6);
        check("post-reset nibble", bus.digit_out, 32'h0);
        check("post-reset valid", {24'h0, bus.digit_valid}, 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
